// File: rtl/rtc_read_sequencer_pkg.sv
// Shared constants, state encoding and field helpers for the RTC read sequencer.
// The 0x2x/0x4x address map is common to the RTC write sequencer.
package rtc_read_sequencer_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned NUM_FIELDS = 6;

    localparam logic [DATA_W-1:0] CMD_TRANSFER  = 8'hF0;

    localparam logic [DATA_W-1:0] CLK_ADDR_SEG  = 8'h21;
    localparam logic [DATA_W-1:0] CLK_ADDR_MIN  = 8'h22;
    localparam logic [DATA_W-1:0] CLK_ADDR_HORA = 8'h23;
    localparam logic [DATA_W-1:0] CLK_ADDR_DIA  = 8'h24;
    localparam logic [DATA_W-1:0] CLK_ADDR_MES  = 8'h25;
    localparam logic [DATA_W-1:0] CLK_ADDR_ANO  = 8'h26;

    localparam logic [DATA_W-1:0] TMR_ADDR_SEG  = 8'h41;
    localparam logic [DATA_W-1:0] TMR_ADDR_MIN  = 8'h42;
    localparam logic [DATA_W-1:0] TMR_ADDR_HORA = 8'h43;

    typedef enum logic [3:0] {
        IDLE, CMD, R_SEG, R_MIN, R_HORA, R_DIA, R_MES, R_ANO, COMMIT
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] seg;
        logic [DATA_W-1:0] min;
        logic [DATA_W-1:0] hora;
        logic [DATA_W-1:0] dia;
        logic [DATA_W-1:0] mes;
        logic [DATA_W-1:0] ano;
    } rtc_time_t;

    function automatic logic is_read_state(input state_t s);
        return (s == R_SEG) || (s == R_MIN) || (s == R_HORA) ||
               (s == R_DIA) || (s == R_MES) || (s == R_ANO);
    endfunction

    function automatic logic [IDX_W-1:0] field_idx(input state_t s);
        case (s)
            R_MIN:   return IDX_W'(1);
            R_HORA:  return IDX_W'(2);
            R_DIA:   return IDX_W'(3);
            R_MES:   return IDX_W'(4);
            R_ANO:   return IDX_W'(5);
            default: return IDX_W'(0);
        endcase
    endfunction

    // Clock set lives at 0x2x, timer set at 0x4x; the timer has no date bytes.
    function automatic logic [DATA_W-1:0] field_addr(input state_t s, input logic clk_set);
        case (s)
            R_SEG:   return clk_set ? CLK_ADDR_SEG  : TMR_ADDR_SEG;
            R_MIN:   return clk_set ? CLK_ADDR_MIN  : TMR_ADDR_MIN;
            R_HORA:  return clk_set ? CLK_ADDR_HORA : TMR_ADDR_HORA;
            R_DIA:   return CLK_ADDR_DIA;
            R_MES:   return CLK_ADDR_MES;
            R_ANO:   return CLK_ADDR_ANO;
            default: return '0;
        endcase
    endfunction

    function automatic state_t next_read(input state_t s, input logic clk_set);
        case (s)
            R_SEG:   return R_MIN;
            R_MIN:   return R_HORA;
            R_HORA:  return clk_set ? R_DIA : COMMIT;
            R_DIA:   return R_MES;
            R_MES:   return R_ANO;
            R_ANO:   return COMMIT;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rtc_read_sequencer_if.sv
// Bus-timing handshake between the read sequencer (master) and the AD bus timing generator (slave).
interface rtc_read_sequencer_if;
    import rtc_read_sequencer_pkg::*;

    logic              dir;
    logic              dat;
    logic              dat_lat;
    logic              cambio_estado;
    logic [DATA_W-1:0] dato_in;
    logic [DATA_W-1:0] dato_dire;
    logic              e_lect;
    logic              rd_wr;

    modport master (
        input  dir, dat, dat_lat, cambio_estado, dato_in,
        output dato_dire, e_lect, rd_wr
    );

    modport slave (
        output dir, dat, dat_lat, cambio_estado, dato_in,
        input  dato_dire, e_lect, rd_wr
    );
endinterface

// File: rtl/rtc_read_sequencer_shadow_bank.sv
// Six shadow bytes filled one at a time, copied to the committed registers in a single cycle.
module rtc_shadow_bank
    import rtc_read_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    input  logic              commit_date,
    output rtc_time_t         committed
);

    logic [DATA_W-1:0] shadow_q [NUM_FIELDS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (wr_en && (wr_idx < IDX_W'(NUM_FIELDS))) begin
            shadow_q[wr_idx] <= wr_data;
        end
    end

    // Date bytes are only refreshed by clock-set reads; timer reads leave them untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            committed <= '0;
        end else if (commit) begin
            committed.seg  <= shadow_q[0];
            committed.min  <= shadow_q[1];
            committed.hora <= shadow_q[2];
            if (commit_date) begin
                committed.dia <= shadow_q[3];
                committed.mes <= shadow_q[4];
                committed.ano <= shadow_q[5];
            end
        end
    end

endmodule

// File: rtl/rtc_read_sequencer.sv
// RTC read sequencer: transfer command, then byte-per-cycle readback of the clock or timer set.
module rtc_read_sequencer
    import rtc_read_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               lectura,
    input  logic               en_clk,
    rtc_read_sequencer_if.master bus,
    output logic [DATA_W-1:0]  seg,
    output logic [DATA_W-1:0]  min,
    output logic [DATA_W-1:0]  hora,
    output logic [DATA_W-1:0]  dia,
    output logic [DATA_W-1:0]  mes,
    output logic [DATA_W-1:0]  ano,
    output logic               term_lect,
    output logic               lect_err
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] dato_dire_q, dato_dire_d;
    logic              e_lect_q, e_lect_d;
    logic              rd_wr_q, rd_wr_d;
    logic              term_lect_q, term_lect_d;
    logic              lect_err_q, lect_err_d;
    logic              captured_q, captured_d;
    logic              mode_q, mode_d;
    logic              wr_en;
    logic              commit;
    rtc_time_t         committed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dato_dire_q <= '0;
            e_lect_q    <= 1'b0;
            rd_wr_q     <= 1'b0;
            term_lect_q <= 1'b0;
            lect_err_q  <= 1'b0;
            captured_q  <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dato_dire_q <= dato_dire_d;
            e_lect_q    <= e_lect_d;
            rd_wr_q     <= rd_wr_d;
            term_lect_q <= term_lect_d;
            lect_err_q  <= lect_err_d;
            captured_q  <= captured_d;
            mode_q      <= mode_d;
        end
    end

    // Strobe priority inside a bus cycle: dir, then dat_lat, then cambio_estado.
    always_comb begin
        state_d     = state_q;
        dato_dire_d = dato_dire_q;
        e_lect_d    = e_lect_q;
        term_lect_d = 1'b0;
        lect_err_d  = lect_err_q;
        captured_d  = captured_q;
        mode_d      = mode_q;
        wr_en       = 1'b0;
        commit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (lectura) begin
                    mode_d     = en_clk;
                    lect_err_d = 1'b0;
                    captured_d = 1'b0;
                    e_lect_d   = 1'b1;
                    state_d    = CMD;
                end
            end
            CMD: begin
                e_lect_d = 1'b1;
                if (bus.dir) begin
                    dato_dire_d = CMD_TRANSFER;
                end else begin
                    if (bus.dat) begin
                        dato_dire_d = '0;
                    end
                    if (bus.cambio_estado) begin
                        e_lect_d = 1'b0;
                        state_d  = R_SEG;
                    end
                end
            end
            R_SEG, R_MIN, R_HORA, R_DIA, R_MES, R_ANO: begin
                e_lect_d = 1'b1;
                if (bus.dir) begin
                    dato_dire_d = field_addr(state_q, mode_q);
                end else begin
                    if (bus.dat_lat) begin
                        wr_en      = 1'b1;
                        captured_d = 1'b1;
                    end
                    // A same-cycle dat_lat still counts as a capture for this byte.
                    if (bus.cambio_estado) begin
                        e_lect_d   = 1'b0;
                        captured_d = 1'b0;
                        if (!(captured_q || bus.dat_lat)) begin
                            lect_err_d = 1'b1;
                        end
                        state_d = next_read(state_q, mode_q);
                    end
                end
            end
            COMMIT: begin
                commit      = 1'b1;
                term_lect_d = 1'b1;
                e_lect_d    = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_wr_d = is_read_state(state_d);
    end

    rtc_shadow_bank u_shadow_bank (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_idx      (field_idx(state_q)),
        .wr_data     (bus.dato_in),
        .commit      (commit),
        .commit_date (mode_q),
        .committed   (committed)
    );

    assign bus.dato_dire = dato_dire_q;
    assign bus.e_lect    = e_lect_q;
    assign bus.rd_wr     = rd_wr_q;
    assign term_lect     = term_lect_q;
    assign lect_err      = lect_err_q;
    assign seg           = committed.seg;
    assign min           = committed.min;
    assign hora          = committed.hora;
    assign dia           = committed.dia;
    assign mes           = committed.mes;
    assign ano           = committed.ano;

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Directed bench for rtc_read_sequencer; the bench plays the bus-timing generator and RTC.
module tb_rtc_read_sequencer;
    import rtc_read_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       lectura;
    logic       en_clk;
    logic [7:0] seg, min, hora, dia, mes, ano;
    logic       term_lect;
    logic       lect_err;

    int          passed = 0;
    int          total  = 0;
    logic        watch  = 1'b0;
    logic [47:0] held   = '0;

    rtc_read_sequencer_if bus();

    rtc_read_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .lectura   (lectura),
        .en_clk    (en_clk),
        .bus       (bus),
        .seg       (seg),
        .min       (min),
        .hora      (hora),
        .dia       (dia),
        .mes       (mes),
        .ano       (ano),
        .term_lect (term_lect),
        .lect_err  (lect_err)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] outs();
        return {seg, min, hora, dia, mes, ano};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Outputs are sampled on the falling edge; while watch is set they must not move.
    task automatic tick();
        @(negedge clk);
        if (watch) check("atomic_outputs", 64'(outs()), 64'(held));
    endtask

    // lat_mode: 0 no dat_lat, 1 single, 2 double (last wins), 3 dat_lat together with cambio_estado
    task automatic bus_cycle(input string tag, input logic [7:0] exp_addr, input logic exp_rw,
                             input logic [1:0] lat_mode, input logic [7:0] data);
        for (int i = 0; i < 20 && bus.e_lect !== 1'b1; i++) tick();
        check({tag, "_e_lect"}, 64'(bus.e_lect), 64'(1));
        bus.dir = 1'b1;
        tick();
        bus.dir = 1'b0;
        check({tag, "_addr"}, 64'(bus.dato_dire), 64'(exp_addr));
        check({tag, "_rd_wr"}, 64'(bus.rd_wr), 64'(exp_rw));
        bus.dat = 1'b1;
        tick();
        if (!exp_rw) check({tag, "_cmd_data"}, 64'(bus.dato_dire), 64'(0));
        bus.dato_in = data;
        case (lat_mode)
            2'd1: begin
                bus.dat_lat = 1'b1;
                tick();
                bus.dat_lat = 1'b0;
            end
            2'd2: begin
                bus.dato_in = ~data;
                bus.dat_lat = 1'b1;
                tick();
                bus.dato_in = data;
                tick();
                bus.dat_lat = 1'b0;
            end
            default: ;
        endcase
        bus.cambio_estado = 1'b1;
        if (lat_mode == 2'd3) bus.dat_lat = 1'b1;
        tick();
        bus.cambio_estado = 1'b0;
        bus.dat_lat       = 1'b0;
        bus.dat           = 1'b0;
    endtask

    task automatic do_read(input logic mode, input logic [47:0] data, input logic [11:0] modes,
                           input logic hold, input logic atomic, input logic next_en);
        logic seen;
        en_clk  = mode;
        lectura = 1'b1;
        held    = outs();
        tick();
        if (!hold) lectura = 1'b0;
        en_clk = next_en;
        check("start_latency", 64'(bus.e_lect), 64'(1));
        check("lect_err_cleared", 64'(lect_err), 64'(0));
        watch = atomic;
        bus_cycle("cmd", CMD_TRANSFER, 1'b0, 2'd1, 8'h00);
        for (int i = 0; i < (mode ? 6 : 3); i++) begin
            bus_cycle($sformatf("byte%0d", i),
                      (mode ? CLK_ADDR_SEG : TMR_ADDR_SEG) + 8'(i), 1'b1,
                      modes[2*i +: 2], data[47 - 8*i -: 8]);
        end
        watch = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            seen = term_lect;
        end
        check("term_lect_pulse", 64'(seen), 64'(1));
        check("e_lect_low_at_end", 64'(bus.e_lect), 64'(0));
    endtask

    task automatic after_term(input logic restart);
        tick();
        check("term_lect_one_cycle", 64'(term_lect), 64'(0));
        check("restart_e_lect", 64'(bus.e_lect), 64'(restart));
    endtask

    initial begin
        reset = 1'b1; lectura = 1'b0; en_clk = 1'b0;
        bus.dir = 1'b0; bus.dat = 1'b0; bus.dat_lat = 1'b0; bus.cambio_estado = 1'b0;
        bus.dato_in = 8'h00;
        tick(); tick();
        check("rst_outputs", 64'(outs()), 64'(0));
        check("rst_e_lect", 64'(bus.e_lect), 64'(0));
        check("rst_rd_wr", 64'(bus.rd_wr), 64'(0));
        check("rst_dato_dire", 64'(bus.dato_dire), 64'(0));
        check("rst_term", 64'(term_lect), 64'(0));
        check("rst_err", 64'(lect_err), 64'(0));
        reset = 1'b0;
        tick();

        // Bus strobes in IDLE are ignored
        bus.dir = 1'b1; bus.dat_lat = 1'b1; bus.cambio_estado = 1'b1; bus.dato_in = 8'hAA;
        tick();
        bus.dir = 1'b0; bus.dat_lat = 1'b0; bus.cambio_estado = 1'b0;
        check("idle_dato_dire", 64'(bus.dato_dire), 64'(0));
        check("idle_e_lect", 64'(bus.e_lect), 64'(0));
        tick();
        check("idle_outputs", 64'(outs()), 64'(0));

        // Clock read with per-cycle atomicity watch
        do_read(1'b1, 48'h45_30_12_07_09_16, 12'h555, 1'b0, 1'b1, 1'b0);
        check("clk_outputs", 64'(outs()), 64'(48'h45_30_12_07_09_16));
        check("clk_err", 64'(lect_err), 64'(0));
        after_term(1'b0);

        // Timer read: double dat_lat on seg, dat_lat with cambio_estado on min
        do_read(1'b0, 48'h10_05_01_00_00_00, 12'h01E, 1'b0, 1'b1, 1'b1);
        check("tmr_outputs", 64'(outs()), 64'(48'h10_05_01_07_09_16));
        after_term(1'b0);

        // Missing dat_lat on the minutes cycle: shadow keeps the timer byte 0x05
        do_read(1'b1, 48'h50_99_13_08_10_17, 12'h551, 1'b0, 1'b0, 1'b0);
        check("miss_outputs", 64'(outs()), 64'(48'h50_05_13_08_10_17));
        check("miss_err", 64'(lect_err), 64'(1));
        after_term(1'b0);

        // lectura held high: the next sequence starts right after term_lect
        do_read(1'b0, 48'h20_21_22_00_00_00, 12'h555, 1'b1, 1'b0, 1'b1);
        check("hold_outputs", 64'(outs()), 64'(48'h20_21_22_08_10_17));
        after_term(1'b1);
        do_read(1'b1, 48'h01_02_03_04_05_06, 12'h555, 1'b0, 1'b0, 1'b0);
        check("second_outputs", 64'(outs()), 64'(48'h01_02_03_04_05_06));
        after_term(1'b0);

        // Reset in the hours cycle of a clock read
        en_clk = 1'b1; lectura = 1'b1;
        tick();
        lectura = 1'b0;
        bus_cycle("rcmd", CMD_TRANSFER, 1'b0, 2'd1, 8'h00);
        bus_cycle("rseg", CLK_ADDR_SEG, 1'b1, 2'd1, 8'h11);
        bus_cycle("rmin", CLK_ADDR_MIN, 1'b1, 2'd1, 8'h12);
        for (int i = 0; i < 20 && bus.e_lect !== 1'b1; i++) tick();
        bus.dir = 1'b1;
        tick();
        bus.dir = 1'b0;
        check("rhora_addr", 64'(bus.dato_dire), 64'(CLK_ADDR_HORA));
        reset = 1'b1;
        #1;
        check("mid_rst_outputs", 64'(outs()), 64'(0));
        check("mid_rst_e_lect", 64'(bus.e_lect), 64'(0));
        check("mid_rst_dato_dire", 64'(bus.dato_dire), 64'(0));
        check("mid_rst_term", 64'(term_lect), 64'(0));
        tick();
        reset = 1'b0;
        tick();
        do_read(1'b1, 48'h33_44_11_02_03_24, 12'h555, 1'b0, 1'b1, 1'b0);
        check("post_rst_outputs", 64'(outs()), 64'(48'h33_44_11_02_03_24));
        check("post_rst_err", 64'(lect_err), 64'(0));
        after_term(1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rtc_read_sequencer.md
# rtc_read_sequencer

Read-side companion to the RTC write sequencer. On a read request it commands the RTC to latch its counters into RAM (command address 0xF0). It then reads back the clock set (seconds, minutes, hours, day, month, year) or the timer set (seconds, minutes, hours) one byte per bus cycle. Each bus cycle is driven by the shared address/data bus-timing generator. Captured bytes go into a shadow bank and are committed to the outputs atomically when the sequence completes, so the display and main FSM never see a half-updated time.

## Interface

- No parameters; all addresses are fixed constants in the shared package.
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- lectura  in  1  read request from the main FSM; sampled in IDLE only
- en_clk  in  1  1 = clock set (6 bytes), 0 = timer set (3 bytes); latched at start
- dir  in  1  address-phase strobe from the bus-timing generator
- dat  in  1  data-phase strobe from the bus-timing generator
- dat_lat  in  1  one-cycle pulse inside the data phase; dato_in is stable
- cambio_estado  in  1  one-cycle pulse; current bus cycle finished
- dato_in  in  8  read data from the AD bus
- dato_dire  out  8  address (or command data) presented to the bus driver
- e_lect  out  1  bus-cycle request to the timing generator
- rd_wr  out  1  0 = write cycle (command), 1 = read cycle
- seg, min, hora  out  8 each  committed time; clock or timer set per last completed read
- dia, mes, ano  out  8 each  committed date; updated only by clock-set reads
- term_lect  out  1  one-cycle pulse when the commit occurs
- lect_err  out  1  sticky; a read cycle ended with no dat_lat; cleared at next start

## Operation

- States: IDLE, CMD, R_SEG, R_MIN, R_HORA, R_DIA, R_MES, R_ANO, COMMIT.
- IDLE:
  - When lectura=1, latch en_clk into mode_q, clear lect_err, set e_lect=1, go to CMD.
  - lectura=1 in any other state is ignored.
- CMD (write cycle, rd_wr=0):
  - dir → dato_dire=0xF0.
  - dat → dato_dire=0x00.
  - cambio_estado → e_lect=0, go to R_SEG.
- Read states (rd_wr=1):
  - dir → dato_dire = the state's address.
  - Clock-set addresses: seg 0x21, min 0x22, hora 0x23, dia 0x24, mes 0x25, ano 0x26.
  - Timer-set addresses: seg 0x41, min 0x42, hora 0x43.
  - dat_lat → shadow[state] ← dato_in and set captured flag.
  - cambio_estado → e_lect=0. If the captured flag is clear, set lect_err. Clear the flag and advance.
- Advance order: R_SEG→R_MIN→R_HORA. Then R_DIA→R_MES→R_ANO→COMMIT if mode_q=1, else COMMIT.
- e_lect re-asserts the cycle after any non-final cambio_estado, i.e. it drops for exactly one cycle between bytes.
- Priority per cycle: dir > dat_lat > cambio_estado. While none is present, e_lect holds 1.
- COMMIT (one cycle):
  - Copy shadow seg/min/hora to the outputs.
  - Copy dia/mes/ano only if mode_q=1.
  - Pulse term_lect, return to IDLE.
- Data is passed raw (BCD as read); no conversion.

## Timing

- Reset: state IDLE; dato_dire=0x00; e_lect=0; rd_wr=0; all data outputs 0x00; term_lect=0; lect_err=0; shadow cleared.
- All outputs are registered and update on the clk edge after the causing strobe.
- Latency from lectura=1 to e_lect=1: one cycle.
- term_lect rises one cycle after the final cambio_estado and lasts exactly one cycle.
- Outputs change only in COMMIT. A sequence interrupted by reset leaves no partial update; outputs go to reset values.
- dat_lat and cambio_estado in the same cycle: capture, then advance (both take effect).
- A second dat_lat in one bus cycle overwrites the shadow byte (last wins).
- dir/dat/dat_lat/cambio_estado while in IDLE: ignored; dato_dire holds.

## Structure

- Shared package holds:
  - state encoding;
  - command constant CMD_TRANSFER=0xF0;
  - clock address constants 0x21–0x26;
  - timer address constants 0x41–0x43.
- The write sequencer shares the 0x2x/0x4x constants.
- One sub-module, rtc_shadow_bank: six 8-bit shadow registers with an indexed write port and a commit strobe (with a date-enable) driving the output registers.

## Test plan

- Clock read: en_clk=1, lectura pulse, model returns 0x45,0x30,0x12,0x07,0x09,0x16 → dato_dire sequence F0,21..26. Outputs seg=0x45 … ano=0x16; one term_lect; lect_err=0.
- Timer read: en_clk=0, data 0x10,0x05,0x01 → addresses F0,41,42,43. seg/min/hora = 0x10/0x05/0x01; dia/mes/ano keep their prior values.
- Atomicity: check outputs every cycle during a clock read → no output changes before COMMIT.
- Missing dat_lat on the R_MIN cycle → lect_err=1 at end, term_lect still pulses. lect_err clears at the next lectura.
- Reset asserted during R_HORA → all outputs 0x00, e_lect=0. A following lectura runs a full sequence normally.
- lectura held high through a sequence → exactly one sequence per IDLE entry; the second starts the cycle after term_lect.
